// File: rtl/lab4_net_router_input_unit.sv
// lab4_net_router_input_unit: buffered ring-router input port with head-entry route compute
typedef struct packed {
  logic [7:0] opaque;
  logic [7:0] src;
  logic [7:0] dest;
} net_hdr_t;

module lab4_net_router_input_unit #(
  parameter int p_payload_nbits = 32,
  parameter int p_num_routers = 8,
  parameter int p_depth = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [$clog2(p_num_routers)-1:0]  router_id,
  input  net_hdr_t                          in_msg_hdr,
  input  logic [p_payload_nbits-1:0]        in_msg_payload,
  input  logic                              in_val,
  output logic                              in_rdy,
  output net_hdr_t                          out_msg_hdr,
  output logic [p_payload_nbits-1:0]        out_msg_payload,
  output logic [1:0]                        out_port,
  output logic                              out_val,
  input  logic                              out_rdy,
  output logic [$clog2(p_depth):0]          num_free
);
  localparam int rw = $clog2(p_num_routers);
  localparam int aw = $clog2(p_depth);
  localparam int ew = $bits(net_hdr_t) + p_payload_nbits;
  localparam logic [aw:0] depth_c = (aw+1)'(p_depth);
  localparam logic [rw-1:0] half_c = rw'(p_num_routers / 2);
  logic [ew-1:0] mem [p_depth];
  logic [aw-1:0] wptr, rptr;
  logic [aw:0] count;
  logic [rw-1:0] fwd;
  logic enq, deq;
  assign in_rdy = count != depth_c;
  assign out_val = count != '0;
  assign num_free = depth_c - count;
  assign enq = in_val && in_rdy;
  assign deq = out_val && out_rdy;
  assign {out_msg_hdr, out_msg_payload} = mem[rptr];
  // forward distance on the ring; ties at half the ring go east
  assign fwd = out_msg_hdr.dest[rw-1:0] - router_id;
  assign out_port = (fwd == '0) ? 2'd0 : (fwd <= half_c) ? 2'd2 : 2'd1;
  // storage is not reset; only pointers and count define validity
  always_ff @(posedge clk)
    if (enq && reset) mem[wptr] <= {in_msg_hdr, in_msg_payload};
  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= enq ? wptr + aw'(1) : wptr;
      rptr <= deq ? rptr + aw'(1) : rptr;
      count <= (enq && !deq) ? count + (aw+1)'(1) : (deq && !enq) ? count - (aw+1)'(1) : count;
    end
endmodule

// File: tb/tb_lab4_net_router_input_unit.sv
// tb_lab4_net_router_input_unit: table vectors plus scoreboard-checked streaming
module tb_lab4_net_router_input_unit;
  logic clk = 0;
  logic reset;
  logic [2:0] router_id;
  net_hdr_t in_msg_hdr, out_msg_hdr;
  logic [31:0] in_msg_payload, out_msg_payload;
  logic in_val, in_rdy, out_val, out_rdy;
  logic [1:0] out_port;
  logic [2:0] num_free;

  lab4_net_router_input_unit dut (
    .clk(clk), .reset(reset), .router_id(router_id),
    .in_msg_hdr(in_msg_hdr), .in_msg_payload(in_msg_payload),
    .in_val(in_val), .in_rdy(in_rdy),
    .out_msg_hdr(out_msg_hdr), .out_msg_payload(out_msg_payload),
    .out_port(out_port), .out_val(out_val), .out_rdy(out_rdy),
    .num_free(num_free)
  );

  always #5 clk = ~clk;

  typedef struct { net_hdr_t h; logic [31:0] p; } msg_t;
  typedef struct { logic [2:0] id; logic [7:0] dest; logic [1:0] port; } rvec_t;
  msg_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] route_of(input int d, input int id);
    int e = (d - id + 8) % 8;
    int w = (id - d + 8) % 8;
    return e == 0 ? 2'd0 : (e <= w ? 2'd2 : 2'd1);
  endfunction

  function automatic net_hdr_t mk_hdr(input logic [7:0] dest);
    net_hdr_t h;
    h.opaque = 8'($urandom);
    h.src = 8'($urandom);
    h.dest = dest;
    return h;
  endfunction

  // called at a falling edge: drive, check against model, clock, update model
  task automatic cyc(input logic v, input logic r, input logic [31:0] p, input net_hdr_t h);
    logic enq, deq;
    in_val = v;
    out_rdy = r;
    in_msg_payload = p;
    in_msg_hdr = h;
    #1;
    chk("in_rdy", 64'(in_rdy), 64'(sb.size() != 4));
    chk("out_val", 64'(out_val), 64'(sb.size() != 0));
    chk("num_free", 64'(num_free), 64'(4 - sb.size()));
    if (sb.size() != 0) begin
      chk("payload", 64'(out_msg_payload), 64'(sb[0].p));
      chk("hdr", 64'(out_msg_hdr), 64'(sb[0].h));
      chk("out_port", 64'(out_port), 64'(route_of(int'(sb[0].h.dest[2:0]), int'(router_id))));
    end
    enq = v && sb.size() != 4;
    deq = r && sb.size() != 0;
    @(posedge clk);
    if (deq) void'(sb.pop_front());
    if (enq) sb.push_back('{h, p});
    @(negedge clk);
  endtask

  rvec_t tbl[7];
  net_hdr_t z;

  initial begin
    tbl[0] = '{3'd2, 8'd2, 2'd0};
    tbl[1] = '{3'd6, 8'd7, 2'd2};
    tbl[2] = '{3'd6, 8'd1, 2'd2};
    tbl[3] = '{3'd6, 8'd2, 2'd2};
    tbl[4] = '{3'd6, 8'd3, 2'd1};
    tbl[5] = '{3'd6, 8'd5, 2'd1};
    tbl[6] = '{3'd6, 8'd6, 2'd0};
    z = '0;
    reset = 0;
    router_id = 3'd2;
    in_val = 0;
    out_rdy = 0;
    in_msg_hdr = '0;
    in_msg_payload = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_val", 64'(out_val), 64'(0));
    chk("rst_in_rdy", 64'(in_rdy), 64'(1));
    chk("rst_num_free", 64'(num_free), 64'(4));
    reset = 1;
    #1;
    chk("idle_out_val", 64'(out_val), 64'(0));
    chk("idle_in_rdy", 64'(in_rdy), 64'(1));
    chk("idle_num_free", 64'(num_free), 64'(4));
    @(negedge clk);

    cyc(1, 0, 32'hdeadbeef, mk_hdr(8'd2));
    chk("single_val", 64'(out_val), 64'(1));
    chk("single_port", 64'(out_port), 64'(0));
    chk("single_payload", 64'(out_msg_payload), 64'hdeadbeef);
    cyc(0, 1, '0, z);
    chk("single_drained", 64'(out_val), 64'(0));

    for (int i = 0; i < 7; i++) begin
      router_id = tbl[i].id;
      cyc(1, 0, 32'(i + 100), mk_hdr(tbl[i].dest));
      chk($sformatf("route_vec%0d", i), 64'(out_port), 64'(tbl[i].port));
      cyc(0, 1, '0, z);
    end

    router_id = 3'd1;
    for (int i = 1; i <= 4; i++) cyc(1, 0, 32'(i), mk_hdr(8'(i)));
    chk("full_in_rdy", 64'(in_rdy), 64'(0));
    chk("full_num_free", 64'(num_free), 64'(0));
    cyc(1, 0, 32'd5, mk_hdr(8'd5));
    chk("full_hold_num_free", 64'(num_free), 64'(0));
    cyc(1, 1, 32'd5, mk_hdr(8'd5));
    chk("full_deq_num_free", 64'(num_free), 64'(1));
    chk("full_deq_in_rdy", 64'(in_rdy), 64'(1));
    cyc(1, 1, 32'd5, mk_hdr(8'd5));
    chk("refill_num_free", 64'(num_free), 64'(1));
    for (int i = 0; i < 4; i++) cyc(0, 1, '0, z);
    chk("fill_drained", 64'(out_val), 64'(0));

    cyc(1, 0, 32'h11, mk_hdr(8'd3));
    cyc(1, 0, 32'h22, mk_hdr(8'd4));
    #2;
    reset = 0;
    #1;
    chk("mid_rst_out_val", 64'(out_val), 64'(0));
    chk("mid_rst_num_free", 64'(num_free), 64'(4));
    chk("mid_rst_in_rdy", 64'(in_rdy), 64'(1));
    sb.delete();
    in_val = 1;
    out_rdy = 1;
    @(negedge clk);
    reset = 1;
    cyc(1, 0, 32'h77, mk_hdr(8'd0));
    chk("post_rst_payload", 64'(out_msg_payload), 64'h77);
    cyc(0, 1, '0, z);

    router_id = 3'd5;
    begin
      int sent = 0;
      int cycles = 0;
      while (sent < 200 && cycles < 5000) begin
        logic v, r;
        v = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
        if (v && sb.size() != 4) sent++;
        cycles++;
        cyc(v, r, $urandom, mk_hdr(8'($urandom)));
      end
      chk("stream_sent", 64'(sent), 64'(200));
      repeat (6) cyc(0, 1, '0, z);
      chk("stream_drained", 64'(out_val), 64'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
